// File: rtl/shift_operand_sequencer.sv
// Operand-2 front end for ARM7 data-processing instructions: sequences Rs/Rm
// register-file reads and presents a canonical barrel-shifter bundle.
module shift_operand_sequencer #(
  parameter int unsigned PC_OFS_IMM = 8,
  parameter int unsigned PC_OFS_REG = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        imm_op,
  input  logic [7:0]  imm8,
  input  logic [3:0]  rot4,
  input  logic        reg_shift,
  input  logic [1:0]  shift_type,
  input  logic [4:0]  shift_imm,
  input  logic [3:0]  rm_idx,
  input  logic [3:0]  rs_idx,
  input  logic [31:0] pc_in,
  output logic [3:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sh_r_in,
  output logic [1:0]  sh_type,
  output logic [7:0]  sh_amt,
  output logic        sh_rrx,
  output logic        busy
);

  localparam logic [1:0] ShLsl = 2'd0;
  localparam logic [1:0] ShLsr = 2'd1;
  localparam logic [1:0] ShAsr = 2'd2;
  localparam logic [1:0] ShRor = 2'd3;

  typedef enum logic [1:0] {StIdle, StReadRs, StReadRm, StOut} state_e;

  state_e      state_q, state_d;
  logic        accept;
  logic [3:0]  rm_idx_q, rm_idx_d;
  logic [3:0]  rs_idx_q, rs_idx_d;
  logic        reg_shift_q, reg_shift_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] sh_r_in_q, sh_r_in_d;
  logic [1:0]  sh_type_q, sh_type_d;
  logic [7:0]  sh_amt_q, sh_amt_d;
  logic        sh_rrx_q, sh_rrx_d;
  logic [7:0]  rs_amt;
  logic [31:0] rm_val;

  assign accept = (state_q == StIdle) && in_valid && !flush;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (imm_op)         state_d = StOut;
          else if (reg_shift) state_d = StReadRs;
          else                state_d = StReadRm;
        end
      end
      StReadRs: state_d = StReadRm;
      StReadRm: state_d = StOut;
      StOut:    if (out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StOut);
    busy      = (state_q != StIdle);
    rf_addr   = 4'd0;
    unique case (state_q)
      StReadRs: rf_addr = rs_idx_q;
      StReadRm: rf_addr = rm_idx_q;
      default:  rf_addr = 4'd0;
    endcase
  end

  // r15 reads see the pipelined PC rather than the register file
  assign rs_amt = (rs_idx_q == 4'd15) ? 8'(pc_q + 32'(PC_OFS_REG)) : rf_data[7:0];
  assign rm_val = (rm_idx_q == 4'd15) ?
                  pc_q + (reg_shift_q ? 32'(PC_OFS_REG) : 32'(PC_OFS_IMM)) : rf_data;

  always_comb begin
    rm_idx_d    = rm_idx_q;
    rs_idx_d    = rs_idx_q;
    reg_shift_d = reg_shift_q;
    pc_d        = pc_q;
    sh_r_in_d   = sh_r_in_q;
    sh_type_d   = sh_type_q;
    sh_amt_d    = sh_amt_q;
    sh_rrx_d    = sh_rrx_q;
    if (accept) begin
      rm_idx_d    = rm_idx;
      rs_idx_d    = rs_idx;
      reg_shift_d = reg_shift;
      pc_d        = pc_in;
      sh_rrx_d    = 1'b0;
      if (imm_op) begin
        sh_r_in_d = {24'b0, imm8};
        sh_type_d = ShRor;
        sh_amt_d  = {3'b0, rot4, 1'b0};
      end else if (reg_shift) begin
        sh_type_d = shift_type;
        sh_amt_d  = 8'd0;
      end else begin
        sh_type_d = shift_type;
        sh_amt_d  = {3'b0, shift_imm};
        // Encoded #0 is special for everything except LSL
        if (shift_imm == 5'd0) begin
          unique case (shift_type)
            ShLsr, ShAsr: sh_amt_d = 8'd32;
            ShRor:        sh_rrx_d = 1'b1;
            default:      sh_amt_d = 8'd0;
          endcase
        end
      end
    end
    if (state_q == StReadRs) sh_amt_d = rs_amt;
    if (state_q == StReadRm) sh_r_in_d = rm_val;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rm_idx_q    <= 4'd0;
      rs_idx_q    <= 4'd0;
      reg_shift_q <= 1'b0;
      pc_q        <= 32'd0;
      sh_r_in_q   <= 32'd0;
      sh_type_q   <= ShLsl;
      sh_amt_q    <= 8'd0;
      sh_rrx_q    <= 1'b0;
    end else begin
      rm_idx_q    <= rm_idx_d;
      rs_idx_q    <= rs_idx_d;
      reg_shift_q <= reg_shift_d;
      pc_q        <= pc_d;
      sh_r_in_q   <= sh_r_in_d;
      sh_type_q   <= sh_type_d;
      sh_amt_q    <= sh_amt_d;
      sh_rrx_q    <= sh_rrx_d;
    end
  end

  assign sh_r_in = sh_r_in_q;
  assign sh_type = sh_type_q;
  assign sh_amt  = sh_amt_q;
  assign sh_rrx  = sh_rrx_q;

endmodule

// File: doc/shift_operand_sequencer.md
Name: shift_operand_sequencer

Overview:
- Operand-2 front end for ARM7 data-processing instructions; sits directly upstream of the barrel shifter.
- Accepts decoded operand-2 fields and sequences register-file reads: Rs first for register-specified shifts, then Rm.
- Canonicalises the ARM shift encodings (LSR/ASR #0 mean #32, ROR #0 means RRX, immediate rotate is 2*rot).
- Presents a stable shifter operand bundle behind a valid/ready handshake.

Parameters:
- PC_OFS_IMM, 8, value added to pc_in when r15 is read for an immediate-shift or immediate operand.
- PC_OFS_REG, 12, value added to pc_in when r15 is read for a register-specified shift.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 at posedge clears state)
- flush  in  1  abort current operation (pipeline flush)
- in_valid  in  1  decoded operand fields valid
- in_ready  out  1  block can accept fields
- imm_op  in  1  I bit: operand 2 is rotated immediate
- imm8  in  8  immediate value
- rot4  in  4  immediate rotate field
- reg_shift  in  1  bit 4: shift amount comes from Rs
- shift_type  in  2  LSL=0, LSR=1, ASR=2, ROR=3
- shift_imm  in  5  immediate shift amount
- rm_idx  in  4  Rm index
- rs_idx  in  4  Rs index
- pc_in  in  32  address of current instruction
- rf_addr  out  4  register-file read address (combinational read)
- rf_data  in  32  register-file read data, same cycle
- out_valid  out  1  shifter bundle valid
- out_ready  in  1  shifter/ALU consumes bundle
- sh_r_in  out  32  value to shift
- sh_type  out  2  canonical shift type
- sh_amt  out  8  canonical shift amount, 0..255
- sh_rrx  out  1  perform RRX (1-bit rotate through carry)
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, READ_RS, READ_RM, OUT. Reset (reset==0) forces IDLE next cycle regardless of state.
- Reset values: in_ready=1 (combinational on IDLE), out_valid=0, sh_r_in=0, sh_type=0, sh_amt=0, sh_rrx=0, busy=0, rf_addr=0.
- in_ready=1 only in IDLE. Accept happens when in_valid && in_ready; all input fields are captured in that cycle.
- Transitions on accept:
  - imm_op=1 -> OUT.
  - reg_shift=1 -> READ_RS.
  - otherwise -> READ_RM.
- READ_RS: rf_addr=rs_idx. Capture amt = value[7:0]; if rs_idx==15, value = pc_in+PC_OFS_REG. Next state READ_RM.
- READ_RM: rf_addr=rm_idx. Capture sh_r_in = rf_data; if rm_idx==15, sh_r_in = pc_in + (reg_shift ? PC_OFS_REG : PC_OFS_IMM). Next state OUT.
- rf_addr=0 in IDLE and OUT.
- Latency from accept cycle N to out_valid=1:
  - immediate operand: N+1
  - immediate shift: N+2
  - register shift: N+3
- Canonicalisation, immediate operand: sh_r_in = {24'b0, imm8}, sh_type=ROR, sh_amt = {3'b0, rot4, 1'b0}, sh_rrx=0. rot4=0 gives amt 0 (no RRX).
- Canonicalisation, immediate shift:
  - LSL: amt = shift_imm (0 means pass-through).
  - LSR/ASR with shift_imm=0: amt=32.
  - ROR with shift_imm=0: sh_rrx=1, amt=0.
  - Otherwise amt = shift_imm, sh_rrx=0.
- Register shift: sh_type=shift_type, sh_amt = Rs[7:0] unmodified (0..255), sh_rrx=0. Amount 0 means pass-through for every type.
- OUT: out_valid=1. All sh_* outputs are held stable until out_ready=1. On out_valid && out_ready -> IDLE; out_valid=0 the next cycle.
- No new accept in the handshake cycle; throughput is one operand per (latency+1) cycles minimum.
- flush=1 in any state -> IDLE next cycle, out_valid=0; the pending bundle is dropped. Flush has priority over accept and handshake; reset has priority over flush.
- busy = (state != IDLE).

Test Plan:
- Immediate operand, imm8=0xFF, rot4=4: accept at cycle 0 -> out_valid at cycle 1 with sh_r_in=0x000000FF, sh_type=ROR, sh_amt=8, sh_rrx=0.
- Immediate shift LSR #0, Rm=r3=0x80000001: out_valid at cycle 2 with sh_type=LSR, sh_amt=32. ROR #0 on r3 gives sh_rrx=1, sh_amt=0. ASR #0 gives sh_amt=32.
- Register shift LSL, Rs=r2=0x00000121, Rm=r5=0xDEADBEEF: rf_addr=2 at cycle 1 and rf_addr=5 at cycle 2. out_valid at cycle 3 with sh_amt=0x21, sh_r_in=0xDEADBEEF.
- PC reads, pc_in=0x1000:
  - Rm=15 with immediate shift -> sh_r_in=0x1008.
  - Rm=15 and Rs=15 with register shift -> sh_r_in=0x100C, sh_amt=0x0C.
- Backpressure: hold out_ready=0 for 5 cycles -> out_valid and sh_* stable, in_ready=0. Raising out_ready -> IDLE and in_ready=1 the next cycle.
- Flush and reset:
  - flush in READ_RS -> out_valid never asserts, IDLE next cycle.
  - reset=0 while in OUT -> all outputs at reset values after the next posedge.
  - flush and in_valid in the same IDLE cycle -> no accept.
